i2s_tx: RTL

//  Downstream of the phase-accumulator sine source: serialises 16-bit stereo samples
//  to an external I2S (Philips) DAC. Produces BCLK/LRCK/SDATA from clk, buffers one

---
 rtl/i2s_tx_if.sv | 31 +++
 rtl/i2s_tx.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2s_tx_if
// Purpose  : Sample handshake between the sine source (master) and the I2S
//            serialiser (slave): one stereo sample per valid/ready transfer.
// Revision : 1.0 - initial release
// ============================================================================
interface i2s_tx_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  sample_valid;
    logic                  sample_ready;
    logic [DATA_WIDTH-1:0] left_in;
    logic [DATA_WIDTH-1:0] right_in;

    modport master (
        output sample_valid,
        output left_in,
        output right_in,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  left_in,
        input  right_in,
        output sample_ready
    );
endinterface
`default_nettype wire

// File: rtl/i2s_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2s_tx
// Purpose  : Philips I2S transmitter. Buffers one stereo sample and shifts it
//            out MSB first with the one-BCLK data delay; repeats on underrun.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_WIDTH = 16,  // must be >= DATA_WIDTH
    parameter int BCLK_DIV   = 4    // must be >= 1
) (
    input  logic     clk,
    input  logic     arst,
    i2s_tx_if.slave  smp,
    output logic     frame_start,
    output logic     underrun,
    output logic     bclk,
    output logic     lrclk,
    output logic     sdata
);

    localparam int FRAME_W = 2 * SLOT_WIDTH;
    localparam int PAD_W   = SLOT_WIDTH - DATA_WIDTH;
    localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int CNT_W   = $clog2(FRAME_W);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_RIGHT = CNT_W'(SLOT_WIDTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]      div_cnt_q,     div_cnt_d;
    logic                  bclk_q,        bclk_d;
    logic [CNT_W-1:0]      bit_cnt_q,     bit_cnt_d;
    logic                  lrclk_q,       lrclk_d;
    logic                  sdata_q,       sdata_d;
    logic [FRAME_W-1:0]    shift_q,       shift_d;
    logic                  ready_q,       ready_d;
    logic [DATA_WIDTH-1:0] hold_l_q,      hold_l_d;
    logic [DATA_WIDTH-1:0] hold_r_q,      hold_r_d;
    logic [DATA_WIDTH-1:0] last_l_q,      last_l_d;
    logic [DATA_WIDTH-1:0] last_r_q,      last_r_d;
    logic                  frame_start_q, frame_start_d;
    logic                  underrun_q,    underrun_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                  w_tick;
    logic                  w_fall;
    logic                  w_load;
    logic                  w_accept;
    logic [CNT_W-1:0]      w_bit_next;
    logic [FRAME_W-1:0]    w_frame;

    // Left-justify a sample inside its slot; the padding bits are zero.
    function automatic logic [SLOT_WIDTH-1:0] to_slot(input logic [DATA_WIDTH-1:0] s);
        return SLOT_WIDTH'(s) << PAD_W;
    endfunction

    assign w_tick     = (div_cnt_q == DIV_LAST);
    assign w_fall     = w_tick & bclk_q;
    assign w_bit_next = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + 1'b1;
    assign w_load     = w_fall & (bit_cnt_q == CNT_LAST);
    assign w_accept   = smp.sample_valid & ready_q;

    // ready_q high means the holding register is empty, so the frame repeats
    // the last sample; a sample accepted this very cycle is not yet visible.
    assign w_frame = ready_q ? {to_slot(last_l_q), to_slot(last_r_q)}
                             : {to_slot(hold_l_q), to_slot(hold_r_q)};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        div_cnt_d     = w_tick ? '0 : div_cnt_q + 1'b1;
        bclk_d        = w_tick ? ~bclk_q : bclk_q;
        bit_cnt_d     = bit_cnt_q;
        lrclk_d       = lrclk_q;
        sdata_d       = sdata_q;
        shift_d       = shift_q;
        ready_d       = ready_q;
        hold_l_d      = hold_l_q;
        hold_r_d      = hold_r_q;
        last_l_d      = last_l_q;
        last_r_d      = last_r_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;

        // The MSB leaving the shifter at bit 0 is the previous frame's LSB,
        // which yields the one-BCLK I2S data delay without extra state.
        if (w_fall) begin
            bit_cnt_d = w_bit_next;
            lrclk_d   = (w_bit_next >= CNT_RIGHT);
            sdata_d   = shift_q[FRAME_W-1];
            shift_d   = w_load ? w_frame : {shift_q[FRAME_W-2:0], 1'b0};
        end

        if (w_load) begin
            frame_start_d = 1'b1;
            underrun_d    = ready_q;
            if (!ready_q) begin
                last_l_d = hold_l_q;
                last_r_d = hold_r_q;
                ready_d  = 1'b1;
            end
        end

        // Accept and holding-release are exclusive: one needs ready_q high,
        // the other needs it low.
        if (w_accept) begin
            hold_l_d = smp.left_in;
            hold_r_d = smp.right_in;
            ready_d  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            div_cnt_q     <= '0;
            bclk_q        <= 1'b0;
            bit_cnt_q     <= CNT_LAST;
            lrclk_q       <= 1'b0;
            sdata_q       <= 1'b0;
            shift_q       <= '0;
            ready_q       <= 1'b1;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            last_l_q      <= '0;
            last_r_q      <= '0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            bclk_q        <= bclk_d;
            bit_cnt_q     <= bit_cnt_d;
            lrclk_q       <= lrclk_d;
            sdata_q       <= sdata_d;
            shift_q       <= shift_d;
            ready_q       <= ready_d;
            hold_l_q      <= hold_l_d;
            hold_r_q      <= hold_r_d;
            last_l_q      <= last_l_d;
            last_r_q      <= last_r_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign smp.sample_ready = ready_q;
    assign frame_start      = frame_start_q;
    assign underrun         = underrun_q;
    assign bclk             = bclk_q;
    assign lrclk            = lrclk_q;
    assign sdata            = sdata_q;

endmodule
`default_nettype wire
